// File: rtl/nn_sequencer.sv
// -----------------------------------------------------------------------------
// nn_sequencer
//
// Frame-level controller for the speech-recognition network. It accepts one
// feature frame, walks the layer chain one layer at a time with a one-hot
// enable, and captures the 2-bit decision of the final classification layer.
// A consecutive-match filter then confirms the decision before `detect` is
// raised.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   frame_valid    in   new feature frame present at the layer-0 input
//   frame_ready    out  block is idle and will accept a frame
//   layer_en       out  one-hot layer enable (bit k -> layer k)
//   class_in       in   decision from the classification layer
//   busy           out  a frame is in flight
//   result_valid   out  one-cycle pulse, result_class is new
//   result_class   out  decision captured for the last frame
//   detect         out  confirmed keyword is held
//   detect_class   out  class of the confirmed keyword (00 when no detect)
//   overrun        out  one-cycle pulse, a frame was dropped
//   clear          in   synchronous clear of the confirmation state
//   dbg_state      out  current FSM state (IDLE=0, RUN=1, DONE=2)
//   dbg_streak     out  current confirmation streak
//
// Handshake: a frame is taken on a clock edge where frame_valid and
// frame_ready are both high. There is no back-pressure on the source: a
// frame_valid seen while frame_ready is low is dropped and reported by a
// one-cycle overrun pulse in the following cycle.
// -----------------------------------------------------------------------------
module nn_sequencer #(
  parameter int NUM_LAYERS   = 5,
  parameter int STAGE_CYCLES = 2,
  parameter int CONFIRM_CNT  = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 frame_valid,
  output logic                                 frame_ready,
  output logic [NUM_LAYERS-1:0]                layer_en,
  input  logic [1:0]                           class_in,
  output logic                                 busy,
  output logic                                 result_valid,
  output logic [1:0]                           result_class,
  output logic                                 detect,
  output logic [1:0]                           detect_class,
  output logic                                 overrun,
  input  logic                                 clear,
  output logic [1:0]                           dbg_state,
  output logic [$clog2(CONFIRM_CNT+1)-1:0]     dbg_streak
);

  localparam int LW  = (NUM_LAYERS   > 1) ? $clog2(NUM_LAYERS)   : 1;
  localparam int SCW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam int STW = $clog2(CONFIRM_CNT + 1);

  localparam logic [LW-1:0]  LAYER_LAST  = LW'(NUM_LAYERS - 1);
  localparam logic [SCW-1:0] STAGE_LAST  = SCW'(STAGE_CYCLES - 1);
  localparam logic [STW-1:0] CONFIRM_MAX = STW'(CONFIRM_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [LW-1:0]  layer_idx;
  logic [SCW-1:0] stage_cnt;
  logic [1:0]     last_class;
  logic [STW-1:0] streak;

  // Next filter state, used only on the RUN -> DONE edge.
  logic [1:0]     cls_eff;
  logic [1:0]     last_nx;
  logic [STW-1:0] streak_nx;
  logic           detect_nx;

  always_comb begin
    // 11 is not a legal class code; it breaks a streak like "none".
    cls_eff   = (class_in == 2'b11) ? 2'b00 : class_in;
    last_nx   = last_class;
    streak_nx = streak;
    if (cls_eff == 2'b00) begin
      streak_nx = '0;
    end else if (cls_eff == last_class) begin
      if (streak != CONFIRM_MAX) begin
        streak_nx = streak + 1'b1;
      end
    end else begin
      last_nx   = cls_eff;
      streak_nx = STW'(1);
    end
    detect_nx = (streak_nx == CONFIRM_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      layer_idx    <= '0;
      stage_cnt    <= '0;
      result_class <= 2'b00;
      last_class   <= 2'b00;
      streak       <= '0;
      detect       <= 1'b0;
      detect_class <= 2'b00;
      overrun      <= 1'b0;
    end else begin
      overrun <= frame_valid && (state != IDLE);

      case (state)
        IDLE: begin
          if (frame_valid) begin
            state     <= RUN;
            layer_idx <= '0;
            stage_cnt <= '0;
          end
        end

        RUN: begin
          if (stage_cnt == STAGE_LAST) begin
            stage_cnt <= '0;
            if (layer_idx == LAYER_LAST) begin
              state        <= DONE;
              result_class <= class_in;
              if (!clear) begin
                last_class   <= last_nx;
                streak       <= streak_nx;
                detect       <= detect_nx;
                detect_class <= detect_nx ? last_nx : 2'b00;
              end
            end else begin
              layer_idx <= layer_idx + 1'b1;
            end
          end else begin
            stage_cnt <= stage_cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Clear has priority over a filter update on the same edge.
      if (clear) begin
        last_class   <= 2'b00;
        streak       <= '0;
        detect       <= 1'b0;
        detect_class <= 2'b00;
      end
    end
  end

  assign frame_ready  = (state == IDLE);
  assign busy         = (state == RUN) || (state == DONE);
  assign result_valid = (state == DONE);
  assign layer_en     = (state == RUN) ? (NUM_LAYERS'(1) << layer_idx) : '0;
  assign dbg_state    = state;
  assign dbg_streak   = streak;

endmodule

// File: tb/tb_nn_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nn_sequencer
//
// Directed bench for nn_sequencer with default parameters (5 layers, 2 cycles
// per layer, confirmation count 3). Cycle c of a frame is the cycle after
// edge E(c-1); the frame is offered in cycle 0.
// -----------------------------------------------------------------------------
module tb_nn_sequencer;

  localparam int NL = 5;
  localparam int S  = 2;
  localparam int NS = NL * S;

  // Clock / reset / inputs
  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          frame_valid = 1'b0;
  logic          clear       = 1'b0;
  logic [1:0]    class_in    = 2'b00;

  // DUT outputs
  logic          frame_ready;
  logic [NL-1:0] layer_en;
  logic          busy;
  logic          result_valid;
  logic [1:0]    result_class;
  logic          detect;
  logic [1:0]    detect_class;
  logic          overrun;
  logic [1:0]    dbg_state;
  logic [1:0]    dbg_streak;

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-cycle record of one frame (index = cycle number 1..NS+2)
  logic [NL-1:0] en_log   [0:NS+2];
  logic          rv_log   [0:NS+2];
  logic          rdy_log  [0:NS+2];
  logic          busy_log [0:NS+2];
  logic          ov_log   [0:NS+2];
  logic          det_log  [0:NS+2];
  logic [1:0]    dcls_log [0:NS+2];
  logic [1:0]    rc_log   [0:NS+2];
  logic [1:0]    stk_log  [0:NS+2];

  nn_sequencer #(
    .NUM_LAYERS  (NL),
    .STAGE_CYCLES(S),
    .CONFIRM_CNT (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .layer_en    (layer_en),
    .class_in    (class_in),
    .busy        (busy),
    .result_valid(result_valid),
    .result_class(result_class),
    .detect      (detect),
    .detect_class(detect_class),
    .overrun     (overrun),
    .clear       (clear),
    .dbg_state   (dbg_state),
    .dbg_streak  (dbg_streak)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- drivers
  // Called in an idle cycle, 1 ns after a rising edge. Offers a frame in
  // that cycle (cycle 0), presents cls during cycle NS, optionally pulses
  // frame_valid in cycle fv_cyc and clear in cycle clr_cyc, and records
  // outputs for cycles 1..NS+2. Returns in cycle NS+2.
  task automatic drive_frame(input logic [1:0] cls, input int fv_cyc,
                             input int clr_cyc);
    frame_valid = 1'b1;
    class_in    = 2'b00;
    for (int c = 1; c <= NS + 2; c++) begin
      @(posedge clk); #1;
      frame_valid = (c == fv_cyc);
      clear       = (c == clr_cyc);
      class_in    = (c == NS) ? cls : 2'b00;
      en_log[c]   = layer_en;
      rv_log[c]   = result_valid;
      rdy_log[c]  = frame_ready;
      busy_log[c] = busy;
      ov_log[c]   = overrun;
      det_log[c]  = detect;
      dcls_log[c] = detect_class;
      rc_log[c]   = result_class;
      stk_log[c]  = dbg_streak;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    #12;
    n_cmp++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", frame_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (layer_en !== 5'b00000) begin n_fail++; $display("FAIL reset_en got=%b exp=00000", layer_en); end
    n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got=%b exp=0", result_valid); end
    n_cmp++; if (result_class !== 2'b00) begin n_fail++; $display("FAIL reset_rc got=%b exp=00", result_class); end
    n_cmp++; if (detect !== 1'b0 || detect_class !== 2'b00) begin n_fail++; $display("FAIL reset_detect got=%b/%b exp=0/00", detect, detect_class); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    n_cmp++; if (dbg_state !== 2'd0 || dbg_streak !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg_state, dbg_streak); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [NL-1:0] one;
    logic [NL-1:0] exp_en;
    one = 1;
    drive_frame(2'b01, 0, 0);
    for (int c = 1; c <= NS + 2; c++) begin
      exp_en = (c <= NS) ? (one << ((c - 1) / S)) : '0;
      n_cmp++; if (en_log[c] !== exp_en) begin n_fail++; $display("FAIL single_en cyc=%0d got=%b exp=%b", c, en_log[c], exp_en); end
      n_cmp++; if (rv_log[c] !== (c == NS + 1)) begin n_fail++; $display("FAIL single_rv cyc=%0d got=%b exp=%b", c, rv_log[c], (c == NS + 1)); end
      n_cmp++; if (rdy_log[c] !== (c == NS + 2)) begin n_fail++; $display("FAIL single_ready cyc=%0d got=%b exp=%b", c, rdy_log[c], (c == NS + 2)); end
      n_cmp++; if (busy_log[c] !== (c <= NS + 1)) begin n_fail++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, busy_log[c], (c <= NS + 1)); end
      n_cmp++; if (ov_log[c] !== 1'b0) begin n_fail++; $display("FAIL single_overrun cyc=%0d got=%b exp=0", c, ov_log[c]); end
    end
    n_cmp++; if (rc_log[NS+1] !== 2'b01) begin n_fail++; $display("FAIL single_rc got=%b exp=01", rc_log[NS+1]); end
    n_cmp++; if (rc_log[NS] !== 2'b00) begin n_fail++; $display("FAIL single_rc_early got=%b exp=00", rc_log[NS]); end
    n_cmp++; if (det_log[NS+1] !== 1'b0) begin n_fail++; $display("FAIL single_detect got=%b exp=0", det_log[NS+1]); end
  endtask

  task automatic test_confirm();
    logic [1:0] seq    [0:3] = '{2'b10, 2'b10, 2'b10, 2'b00};
    logic       exp_det[0:3] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] exp_dc [0:3] = '{2'b00, 2'b00, 2'b10, 2'b00};
    do_clear();
    for (int i = 0; i < 4; i++) begin
      drive_frame(seq[i], 0, 0);
      n_cmp++; if (det_log[NS+1] !== exp_det[i]) begin n_fail++; $display("FAIL confirm_detect frame=%0d got=%b exp=%b", i, det_log[NS+1], exp_det[i]); end
      n_cmp++; if (dcls_log[NS+1] !== exp_dc[i]) begin n_fail++; $display("FAIL confirm_dclass frame=%0d got=%b exp=%b", i, dcls_log[NS+1], exp_dc[i]); end
      if (i == 2) begin
        n_cmp++; if (det_log[NS] !== 1'b0) begin n_fail++; $display("FAIL confirm_detect_early got=%b exp=0", det_log[NS]); end
      end
    end
  endtask

  task automatic test_sequence();
    logic [1:0] seq    [0:5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    logic       exp_det[0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] exp_dc [0:5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
    logic [1:0] exp_stk[0:5] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd3};
    do_clear();
    for (int i = 0; i < 6; i++) begin
      drive_frame(seq[i], 0, 0);
      n_cmp++; if (det_log[NS+1] !== exp_det[i]) begin n_fail++; $display("FAIL seq_detect frame=%0d got=%b exp=%b", i, det_log[NS+1], exp_det[i]); end
      n_cmp++; if (dcls_log[NS+1] !== exp_dc[i]) begin n_fail++; $display("FAIL seq_dclass frame=%0d got=%b exp=%b", i, dcls_log[NS+1], exp_dc[i]); end
      n_cmp++; if (stk_log[NS+1] !== exp_stk[i]) begin n_fail++; $display("FAIL seq_streak frame=%0d got=%0d exp=%0d", i, stk_log[NS+1], exp_stk[i]); end
    end
    // Clear while idle drops a held detection.
    do_clear();
    n_cmp++; if (detect !== 1'b0 || detect_class !== 2'b00) begin n_fail++; $display("FAIL idle_clear_detect got=%b/%b exp=0/00", detect, detect_class); end
    n_cmp++; if (dbg_streak !== 2'd0) begin n_fail++; $display("FAIL idle_clear_streak got=%0d exp=0", dbg_streak); end
  endtask

  task automatic test_class3();
    logic [1:0] seq    [0:2] = '{2'b10, 2'b11, 2'b10};
    logic [1:0] exp_stk[0:2] = '{2'd1, 2'd0, 2'd1};
    do_clear();
    for (int i = 0; i < 3; i++) begin
      drive_frame(seq[i], 0, 0);
      n_cmp++; if (rc_log[NS+1] !== seq[i]) begin n_fail++; $display("FAIL class3_rc frame=%0d got=%b exp=%b", i, rc_log[NS+1], seq[i]); end
      n_cmp++; if (stk_log[NS+1] !== exp_stk[i]) begin n_fail++; $display("FAIL class3_streak frame=%0d got=%0d exp=%0d", i, stk_log[NS+1], exp_stk[i]); end
      n_cmp++; if (det_log[NS+1] !== 1'b0) begin n_fail++; $display("FAIL class3_detect frame=%0d got=%b exp=0", i, det_log[NS+1]); end
    end
  endtask

  task automatic test_overrun();
    do_clear();
    drive_frame(2'b01, 5, 0);
    for (int c = 1; c <= NS + 2; c++) begin
      n_cmp++; if (ov_log[c] !== (c == 6)) begin n_fail++; $display("FAIL overrun_pulse cyc=%0d got=%b exp=%b", c, ov_log[c], (c == 6)); end
      n_cmp++; if (rv_log[c] !== (c == NS + 1)) begin n_fail++; $display("FAIL overrun_rv cyc=%0d got=%b exp=%b", c, rv_log[c], (c == NS + 1)); end
    end
    n_cmp++; if (en_log[7] !== 5'b01000) begin n_fail++; $display("FAIL overrun_en7 got=%b exp=01000", en_log[7]); end
    n_cmp++; if (rdy_log[NS+2] !== 1'b1 || busy_log[NS+2] !== 1'b0) begin n_fail++; $display("FAIL overrun_idle got=%b/%b exp=1/0", rdy_log[NS+2], busy_log[NS+2]); end
    n_cmp++; if (en_log[NS+2] !== 5'b00000) begin n_fail++; $display("FAIL overrun_no_restart got=%b exp=00000", en_log[NS+2]); end
  endtask

  task automatic test_clear_at_done();
    do_clear();
    drive_frame(2'b01, 0, 0);
    drive_frame(2'b01, 0, 0);
    n_cmp++; if (stk_log[NS+1] !== 2'd2) begin n_fail++; $display("FAIL clr_pre_streak got=%0d exp=2", stk_log[NS+1]); end
    drive_frame(2'b01, 0, NS);
    n_cmp++; if (rc_log[NS+1] !== 2'b01) begin n_fail++; $display("FAIL clr_rc got=%b exp=01", rc_log[NS+1]); end
    n_cmp++; if (det_log[NS+1] !== 1'b0) begin n_fail++; $display("FAIL clr_detect got=%b exp=0", det_log[NS+1]); end
    n_cmp++; if (stk_log[NS+1] !== 2'd0) begin n_fail++; $display("FAIL clr_streak got=%0d exp=0", stk_log[NS+1]); end
    drive_frame(2'b01, 0, 0);
    n_cmp++; if (stk_log[NS+1] !== 2'd1) begin n_fail++; $display("FAIL clr_next_streak got=%0d exp=1", stk_log[NS+1]); end
    n_cmp++; if (det_log[NS+1] !== 1'b0) begin n_fail++; $display("FAIL clr_next_detect got=%b exp=0", det_log[NS+1]); end
  endtask

  task automatic test_reset_mid();
    logic saw_rv;
    frame_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      frame_valid = 1'b0;
    end
    n_cmp++; if (busy !== 1'b1 || layer_en !== 5'b00100) begin n_fail++; $display("FAIL rstmid_pre got=%b/%b exp=1/00100", busy, layer_en); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (layer_en !== 5'b00000) begin n_fail++; $display("FAIL rstmid_en got=%b exp=00000", layer_en); end
    n_cmp++; if (busy !== 1'b0 || frame_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy got=%b/%b exp=0/1", busy, frame_ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_rv = 1'b0;
    for (int c = 0; c < NS + 2; c++) begin
      @(posedge clk); #1;
      saw_rv = saw_rv | result_valid;
    end
    n_cmp++; if (saw_rv !== 1'b0) begin n_fail++; $display("FAIL rstmid_phantom_rv got=%b exp=0", saw_rv); end
    drive_frame(2'b01, 0, 0);
    n_cmp++; if (rv_log[NS] !== 1'b0 || rv_log[NS+1] !== 1'b1) begin n_fail++; $display("FAIL rstmid_latency got=%b%b exp=01", rv_log[NS], rv_log[NS+1]); end
    n_cmp++; if (rc_log[NS+1] !== 2'b01) begin n_fail++; $display("FAIL rstmid_rc got=%b exp=01", rc_log[NS+1]); end
    n_cmp++; if (stk_log[NS+1] !== 2'd1) begin n_fail++; $display("FAIL rstmid_streak got=%0d exp=1", stk_log[NS+1]); end
    n_cmp++; if (rdy_log[NS+2] !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", rdy_log[NS+2]); end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_single();
    test_confirm();
    test_sequence();
    test_class3();
    test_overrun();
    test_clear_at_done();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
